// File: rtl/chad_intc.sv
// Interrupt controller for the chad core: edge-latched pending bits, per-vector
// enables, fixed lowest-index-wins priority, and a 4-entry I/O register file.
module chad_intc #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             hold,
  input  logic [14:0]      src,
  input  logic             io_sel,
  input  logic [1:0]       io_addr,
  input  logic             io_wr,
  input  logic             io_rd,
  input  logic [WIDTH-1:0] io_din,
  output logic [WIDTH-1:0] io_dout,
  output logic             irq,
  output logic [3:0]       ivec,
  input  logic             iack
);

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_PENDING = 2'd1;
  localparam logic [1:0] A_TRIGGER = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  logic [15:1]      r_src_d;
  logic [15:1]      r_pend;
  logic [15:1]      r_en;
  logic             r_gie;
  logic [3:0]       r_last;
  logic             r_irq;
  logic [3:0]       r_ivec;
  logic [WIDTH-1:0] r_dout;

  logic [15:1]      w_src;
  logic [15:1]      w_rise;
  logic             w_wr;
  logic             w_rd;
  logic             w_ack;
  logic [15:1]      w_clr;
  logic [15:1]      w_trig;
  logic [15:1]      w_ackbit;
  logic [15:1]      w_pend_next;
  logic [15:1]      w_en_next;
  logic             w_gie_next;
  logic [3:0]       w_last_next;
  logic [15:1]      w_masked;
  logic             w_irq_next;
  logic [3:0]       w_winner;
  logic [3:0]       w_ivec_next;
  logic [15:0]      w_rdata;
  logic [WIDTH-1:0] w_dout_next;

  assign w_src  = src;
  assign w_rise = w_src & ~r_src_d;
  assign w_wr   = io_sel & io_wr;
  assign w_rd   = io_sel & io_rd;
  // Only an acknowledge the core actually advances on may retire a vector.
  assign w_ack  = iack & ~hold & r_irq;

  assign w_clr  = (w_wr && io_addr == A_PENDING) ? io_din[15:1] : 15'd0;
  assign w_trig = (w_wr && io_addr == A_TRIGGER) ? io_din[15:1] : 15'd0;

  // Set terms are OR'd last so an edge or trigger always beats a clear or ack.
  generate
    for (genvar gi = 1; gi <= 15; gi++) begin : g_pend
      assign w_ackbit[gi]    = w_ack && (r_ivec == 4'(gi));
      assign w_pend_next[gi] = (r_pend[gi] & ~w_clr[gi] & ~w_ackbit[gi])
                               | w_rise[gi] | w_trig[gi];
    end
  endgenerate

  assign w_en_next   = (w_wr && io_addr == A_ENABLE) ? io_din[15:1] : r_en;
  assign w_gie_next  = (w_wr && io_addr == A_ENABLE) ? io_din[0]
                                                      : (r_gie & ~w_ack);
  assign w_last_next = w_ack ? r_ivec : r_last;

  assign w_masked   = w_pend_next & w_en_next;
  assign w_irq_next = w_gie_next & (|w_masked);

  always_comb begin
    w_winner = 4'd0;
    for (int i = 15; i >= 1; i--) begin
      if (w_masked[i]) w_winner = 4'(i);
    end
  end

  assign w_ivec_next = w_irq_next ? w_winner : r_ivec;

  always_comb begin
    w_rdata = 16'h0000;
    case (io_addr)
      A_ENABLE:  w_rdata = {r_en, r_gie};
      A_PENDING: w_rdata = {r_pend, 1'b0};
      A_TRIGGER: w_rdata = 16'h0000;
      A_STATUS:  w_rdata = {11'd0, r_irq, r_last};
      default:   w_rdata = 16'h0000;
    endcase
  end

  assign w_dout_next = w_rd ? WIDTH'(w_rdata) : r_dout;

  generate
    if (WIDTH > 16) begin : g_upper
      logic w_unused_upper;
      assign w_unused_upper = ^io_din[WIDTH-1:16];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetq) begin
      r_src_d <= '0;
      r_pend  <= '0;
      r_en    <= '0;
      r_gie   <= 1'b0;
      r_last  <= 4'd0;
      r_irq   <= 1'b0;
      r_ivec  <= 4'd0;
      r_dout  <= '0;
    end else begin
      r_src_d <= w_src;
      r_pend  <= w_pend_next;
      r_en    <= w_en_next;
      r_gie   <= w_gie_next;
      r_last  <= w_last_next;
      r_irq   <= w_irq_next;
      r_ivec  <= w_ivec_next;
      r_dout  <= w_dout_next;
    end
  end

  assign io_dout = r_dout;
  assign irq     = r_irq;
  assign ivec    = r_ivec;

endmodule

// File: tb/tb_chad_intc.sv
// Directed bench for chad_intc: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_chad_intc;

  localparam int WIDTH = 18;

  logic             clk;
  logic             resetq;
  logic             hold;
  logic [14:0]      src;
  logic             io_sel;
  logic [1:0]       io_addr;
  logic             io_wr;
  logic             io_rd;
  logic [WIDTH-1:0] io_din;
  logic [WIDTH-1:0] io_dout;
  logic             irq;
  logic [3:0]       ivec;
  logic             iack;

  int n_checks;
  int n_fails;

  chad_intc #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .hold    (hold),
    .src     (src),
    .io_sel  (io_sel),
    .io_addr (io_addr),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .io_din  (io_din),
    .io_dout (io_dout),
    .irq     (irq),
    .ivec    (ivec),
    .iack    (iack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic io_write(input logic [1:0] addr, input logic [15:0] data);
    io_sel  = 1'b1;
    io_wr   = 1'b1;
    io_addr = addr;
    io_din  = WIDTH'(data);
    tick();
    io_sel  = 1'b0;
    io_wr   = 1'b0;
    io_din  = '0;
  endtask

  task automatic io_read(input logic [1:0] addr);
    io_sel  = 1'b1;
    io_rd   = 1'b1;
    io_addr = addr;
    tick();
    io_sel  = 1'b0;
    io_rd   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    resetq = 1'b0; hold = 1'b0; src = '0; io_sel = 1'b0; io_addr = 2'd0;
    io_wr = 1'b0; io_rd = 1'b0; io_din = '0; iack = 1'b0;
    #1;
    tick();
    tick();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ivec", 32'(ivec), 32'd0);
    check("rst_dout", 32'(io_dout), 32'd0);
    resetq = 1'b1;
    io_read(2'd0);
    check("rst_enable", 32'(io_dout), 32'h0000);

    // Scenario 1: single source, ack, STATUS
    io_write(2'd0, 16'h0005);
    check("s1_idle_irq", 32'(irq), 32'd0);
    src = 15'h0002;
    tick();
    src = '0;
    check("s1_irq", 32'(irq), 32'd1);
    check("s1_ivec", 32'(ivec), 32'd2);
    iack = 1'b1;
    tick();
    iack = 1'b0;
    check("s1_ack_irq", 32'(irq), 32'd0);
    io_read(2'd3);
    check("s1_status", 32'(io_dout), 32'h0002);
    io_read(2'd0);
    check("s1_gie_clr", 32'(io_dout), 32'h0004);
    io_read(2'd1);
    check("s1_pend_clr", 32'(io_dout), 32'h0000);

    // Scenario 2: simultaneous vectors 7 and 3
    io_write(2'd0, 16'hFFFF);
    src = 15'h0044;
    tick();
    src = '0;
    check("s2_irq", 32'(irq), 32'd1);
    check("s2_ivec", 32'(ivec), 32'd3);
    iack = 1'b1;
    tick();
    iack = 1'b0;
    check("s2_ack_irq", 32'(irq), 32'd0);
    check("s2_ivec_hold", 32'(ivec), 32'd3);
    io_write(2'd0, 16'hFFFF);
    check("s2_reen_irq", 32'(irq), 32'd1);
    check("s2_reen_ivec", 32'(ivec), 32'd7);
    iack = 1'b1;
    tick();
    iack = 1'b0;
    check("s2_ack2_irq", 32'(irq), 32'd0);

    // Scenario 3: iack ignored under hold
    io_write(2'd0, 16'hFFFF);
    src = 15'h0010;
    tick();
    src = '0;
    check("s3_ivec", 32'(ivec), 32'd5);
    hold = 1'b1;
    iack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        io_sel = 1'b1; io_rd = 1'b1; io_addr = 2'd1;
      end
      tick();
      check("s3_hold_irq", 32'(irq), 32'd1);
      check("s3_hold_ivec", 32'(ivec), 32'd5);
    end
    io_sel = 1'b0; io_rd = 1'b0;
    check("s3_hold_pend", 32'(io_dout), 32'h0020);
    hold = 1'b0;
    tick();
    iack = 1'b0;
    check("s3_ack_irq", 32'(irq), 32'd0);
    io_read(2'd1);
    check("s3_pend_clr", 32'(io_dout), 32'h0000);

    // Scenario 4: set beats clear; software trigger
    io_write(2'd2, 16'h0010);
    io_read(2'd1);
    check("s4_trig4", 32'(io_dout), 32'h0010);
    src = 15'h0008;
    io_write(2'd1, 16'h0010);
    io_read(2'd1);
    check("s4_set_wins", 32'(io_dout), 32'h0010);
    io_write(2'd1, 16'h0010);
    io_read(2'd1);
    check("s4_clear", 32'(io_dout), 32'h0000);
    src = '0;
    io_read(2'd2);
    check("s4_trig_rd0", 32'(io_dout), 32'h0000);
    io_write(2'd2, 16'h8000);
    check("s4_gie0_irq", 32'(irq), 32'd0);
    io_write(2'd0, 16'h8001);
    check("s4_irq15", 32'(irq), 32'd1);
    check("s4_ivec15", 32'(ivec), 32'd15);
    iack = 1'b1;
    tick();
    iack = 1'b0;
    check("s4_ack_irq", 32'(irq), 32'd0);

    // Scenario 5: all sources masked, then enable only vector 9
    io_write(2'd0, 16'h0000);
    src = 15'h7FFF;
    tick();
    src = '0;
    tick();
    check("s5_masked_irq", 32'(irq), 32'd0);
    io_read(2'd1);
    check("s5_pend_all", 32'(io_dout), 32'hFFFE);
    io_write(2'd0, 16'h0201);
    check("s5_irq9", 32'(irq), 32'd1);
    check("s5_ivec9", 32'(ivec), 32'd9);

    // Scenario 6: reset while irq asserted
    resetq = 1'b0;
    tick();
    check("s6_irq", 32'(irq), 32'd0);
    check("s6_ivec", 32'(ivec), 32'd0);
    check("s6_dout", 32'(io_dout), 32'd0);
    resetq = 1'b1;
    io_read(2'd1);
    check("s6_pend", 32'(io_dout), 32'h0000);

    // Source high across reset release registers a single edge
    src = 15'h0001;
    resetq = 1'b0;
    tick();
    resetq = 1'b1;
    tick();
    io_read(2'd1);
    check("s7_rel_edge", 32'(io_dout), 32'h0002);
    src = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
